// File: rtl/eq_coeff_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// eq_coeff_pkg : shared constants, coefficient select codes and FSM states
// Rev 1.0
// ---------------------------------------------------------------------------
package eq_coeff_pkg;

   localparam int COEFF_W_DEF = 18;

   localparam logic [2:0] SEL_A0 = 3'd0;
   localparam logic [2:0] SEL_A1 = 3'd1;
   localparam logic [2:0] SEL_A2 = 3'd2;
   localparam logic [2:0] SEL_B0 = 3'd3;
   localparam logic [2:0] SEL_B1 = 3'd4;
   localparam logic [2:0] SEL_B2 = 3'd5;

   // 1.0 in Q2.(COEFF_W_DEF-2)
   localparam logic [COEFF_W_DEF-1:0] UNITY_Q = COEFF_W_DEF'(1) << (COEFF_W_DEF - 2);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ARMED  = 2'd1,
      UPDATE = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/eq_coeff_bank.sv
`default_nettype none
// ---------------------------------------------------------------------------
// eq_coeff_bank : shadow/active coefficient set for one biquad band
// Rev 1.0
// ---------------------------------------------------------------------------
module eq_coeff_bank
   import eq_coeff_pkg::*;
#(
   parameter int COEFF_W = COEFF_W_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   i_ld,
   input  logic [2:0]             i_sel,
   input  logic [COEFF_W-1:0]     i_data,
   input  logic                   i_copy,
   output logic [6*COEFF_W-1:0]   o_act,
   output logic                   o_dirty
`ifdef EQ_COEFF_READBACK_EN
   ,
   output logic [6*COEFF_W-1:0]   o_shd
`endif
);

   localparam logic [COEFF_W-1:0]   c_UNITY = COEFF_W'(1) << (COEFF_W - 2);
   localparam logic [COEFF_W-1:0]   c_ZERO  = '0;
   // Packing from LSB: A0, A1, A2, B0, B1, B2 -> passthrough has A0 = B0 = 1.0
   localparam logic [6*COEFF_W-1:0] c_RESET = {c_ZERO, c_ZERO, c_UNITY,
                                               c_ZERO, c_ZERO, c_UNITY};

   logic [6*COEFF_W-1:0] r_shd;
   logic [6*COEFF_W-1:0] r_act;
   logic                 r_dirty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_shd   <= c_RESET;
         r_act   <= c_RESET;
         r_dirty <= 1'b0;
      end else begin
         if (i_ld) begin
            for (int s = 0; s < 6; s++) begin
               if (i_sel == 3'(s)) begin
                  r_shd[s*COEFF_W +: COEFF_W] <= i_data;
               end
            end
            r_dirty <= 1'b1;
         end
         if (i_copy) begin
            r_act   <= r_shd;
            r_dirty <= 1'b0;
         end
      end
   end

   assign o_act   = r_act;
   assign o_dirty = r_dirty;
`ifdef EQ_COEFF_READBACK_EN
   assign o_shd   = r_shd;
`endif

endmodule
`default_nettype wire

// File: rtl/eq_coeff_loader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// eq_coeff_loader : stages biquad coefficients, commits them on a sample tick
// Rev 1.0 -- define EQ_COEFF_READBACK_EN to add the registered readback port
// ---------------------------------------------------------------------------
module eq_coeff_loader
   import eq_coeff_pkg::*;
#(
   parameter int NUM_BANDS  = 4,
   parameter int COEFF_W    = COEFF_W_DEF,
   parameter int BAND_IDX_W = 3
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             wr_valid,
   output logic                             wr_ready,
   input  logic [BAND_IDX_W-1:0]            wr_band,
   input  logic [2:0]                       wr_sel,
   input  logic [COEFF_W-1:0]               wr_data,
   input  logic                             commit_req,
   output logic                             commit_ack,
   input  logic                             sample_tick,
   output logic [NUM_BANDS*3*COEFF_W-1:0]   coeff_a,
   output logic [NUM_BANDS*3*COEFF_W-1:0]   coeff_b,
   output logic [NUM_BANDS-1:0]             coeff_we,
   output logic [NUM_BANDS-1:0]             coeff_set,
   output logic                             busy,
   output logic                             err
`ifdef EQ_COEFF_READBACK_EN
   ,
   input  logic [BAND_IDX_W-1:0]            rd_band,
   input  logic [2:0]                       rd_sel,
   input  logic                             rd_src,
   output logic [COEFF_W-1:0]               rd_data
`endif
);

   localparam logic [BAND_IDX_W:0] c_NUM_BANDS = (BAND_IDX_W + 1)'(NUM_BANDS);

   state_t                 r_state;
   state_t                 w_state_nx;
   logic [NUM_BANDS-1:0]   w_dirty;
   logic [NUM_BANDS-1:0]   w_pick;
   logic [NUM_BANDS-1:0]   w_copy;
   logic [NUM_BANDS-1:0]   w_ld;
   logic [NUM_BANDS-1:0]   r_we;
   logic [NUM_BANDS-1:0]   r_set;
   logic                   r_err;
   logic                   w_wr_fire;
   logic                   w_wr_legal;
   logic [6*COEFF_W-1:0]   w_act [NUM_BANDS];
`ifdef EQ_COEFF_READBACK_EN
   logic [6*COEFF_W-1:0]   w_shd [NUM_BANDS];
   logic [COEFF_W-1:0]     w_rd_mux;
   logic [COEFF_W-1:0]     r_rd_data;
`endif

   assign wr_ready   = (r_state == IDLE);
   assign w_wr_fire  = wr_valid & wr_ready;
   assign w_wr_legal = (wr_sel <= SEL_B2) && ({1'b0, wr_band} < c_NUM_BANDS);

   // Isolate the lowest set dirty bit: bands are served in ascending order
   assign w_pick = w_dirty & (~w_dirty + NUM_BANDS'(1));

   for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
      assign w_ld[b] = w_wr_fire & w_wr_legal & (wr_band == BAND_IDX_W'(b));

      eq_coeff_bank #(
         .COEFF_W (COEFF_W)
      ) u_bank (
         .clk     (clk),
         .rst     (rst),
         .i_ld    (w_ld[b]),
         .i_sel   (wr_sel),
         .i_data  (wr_data),
         .i_copy  (w_copy[b]),
         .o_act   (w_act[b]),
         .o_dirty (w_dirty[b])
`ifdef EQ_COEFF_READBACK_EN
         ,
         .o_shd   (w_shd[b])
`endif
      );

      assign coeff_a[b*3*COEFF_W +: 3*COEFF_W] = w_act[b][0 +: 3*COEFF_W];
      assign coeff_b[b*3*COEFF_W +: 3*COEFF_W] = w_act[b][3*COEFF_W +: 3*COEFF_W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nx;
      end
   end

   // The first copy fires on the tick edge itself so the first coeff_we
   // appears one cycle after the tick; DONE follows once the mask is empty.
   always_comb begin
      w_state_nx = r_state;
      w_copy     = '0;
      case (r_state)
         IDLE: begin
            if (commit_req) w_state_nx = ARMED;
         end
         ARMED: begin
            if (sample_tick) begin
               if (w_dirty != '0) begin
                  w_copy     = w_pick;
                  w_state_nx = UPDATE;
               end else begin
                  w_state_nx = DONE;
               end
            end
         end
         UPDATE: begin
            if (w_dirty != '0) w_copy = w_pick;
            else               w_state_nx = DONE;
         end
         DONE: begin
            w_state_nx = IDLE;
         end
         default: begin
            w_state_nx = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_we  <= '0;
         r_set <= '0;
         r_err <= 1'b0;
      end else begin
         r_we  <= w_copy;
         r_set <= r_set | w_copy;
         r_err <= r_err | (w_wr_fire & ~w_wr_legal);
      end
   end

   assign coeff_we   = r_we;
   assign coeff_set  = r_set;
   assign err        = r_err;
   assign commit_ack = (r_state == DONE);
   assign busy       = (r_state != IDLE);

`ifdef EQ_COEFF_READBACK_EN
   // Unmatched band or select codes fall through to zero
   always_comb begin
      w_rd_mux = '0;
      for (int b = 0; b < NUM_BANDS; b++) begin
         for (int s = 0; s < 6; s++) begin
            if ((rd_band == BAND_IDX_W'(b)) && (rd_sel == 3'(s))) begin
               w_rd_mux = rd_src ? w_act[b][s*COEFF_W +: COEFF_W]
                                 : w_shd[b][s*COEFF_W +: COEFF_W];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_data <= '0;
      end else begin
         r_rd_data <= w_rd_mux;
      end
   end

   assign rd_data = r_rd_data;
`endif

endmodule
`default_nettype wire

// File: doc/eq_coeff_loader.md
Name: eq_coeff_loader

Overview:
Host-side controller that stages biquad EQ coefficients (A0..A2, B0..B2, signed Q2.16) for NUM_BANDS filter sections.
- Writes land in a shadow bank; the live EQ datapath keeps running on the active bank.
- On commit, the block waits for the next audio sample boundary, then copies shadow to active one dirty band per cycle, pulsing that band's coeff_we.
- Sits between the control interface (UART/MCU register decoder) and the EQ biquad cascade.

Parameters:
NUM_BANDS, 4, number of biquad bands served (1..8)
COEFF_W, 18, coefficient width, signed two's complement Q2.(COEFF_W-2)
BAND_IDX_W, 3, width of band index (must satisfy 2^BAND_IDX_W >= NUM_BANDS)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
wr_valid  in  1  host write request
wr_ready  out  1  write accepted when wr_valid & wr_ready
wr_band  in  BAND_IDX_W  target band
wr_sel  in  3  0=A0 1=A1 2=A2 3=B0 4=B1 5=B2; 6,7 illegal
wr_data  in  COEFF_W  coefficient value
commit_req  in  1  one-cycle pulse: apply staged coefficients
commit_ack  out  1  one-cycle pulse when update complete
sample_tick  in  1  one-cycle pulse at audio frame boundary, already synchronised to clk
coeff_a  out  NUM_BANDS*3*COEFF_W  active A0..A2 per band, band 0 at LSBs, A0 lowest within band
coeff_b  out  NUM_BANDS*3*COEFF_W  active B0..B2, same packing
coeff_we  out  NUM_BANDS  one-cycle pulse on the cycle a band's active set changes
coeff_set  out  NUM_BANDS  level: band has received at least one commit since reset
busy  out  1  high in ARMED/UPDATE/DONE
err  out  1  sticky: illegal wr_sel or wr_band >= NUM_BANDS seen; cleared only by rst

Behaviour:
- Clock and reset: clk is the only clock. rst is synchronous and active-high.
- Reset values:
  - Active and shadow banks hold unity passthrough: A0 = B0 = 2^(COEFF_W-2) (65536 at default), all others 0.
  - Dirty mask 0; coeff_we, coeff_set, commit_ack, err all 0.
  - wr_ready 1; state IDLE.
- IDLE:
  - wr_ready = 1.
  - Accepted legal write: updates shadow[wr_band][wr_sel] and sets dirty[wr_band] on the next edge.
  - Illegal write: accepted (handshake completes), shadow untouched, err set.
  - commit_req -> ARMED. If commit_req and a write coincide, the write is applied and included in the commit.
- ARMED:
  - wr_ready = 0.
  - Waits for sample_tick. On sample_tick -> UPDATE, with scan pointer = lowest dirty band.
  - Dirty mask 0 at entry: still waits for sample_tick, then goes directly to DONE with no coeff_we pulse.
- UPDATE:
  - One dirty band per cycle, ascending order: copy shadow to active, pulse coeff_we[b], set coeff_set[b], clear dirty[b].
  - Leave when no dirty bands remain -> DONE.
  - Latency from sample_tick to last coeff_we = number of dirty bands.
- DONE: commit_ack = 1 for one cycle -> IDLE.
- commit_req outside IDLE is ignored (not queued).
- sample_tick outside ARMED is ignored.
- Active outputs are registers; they change only on the same edge that raises coeff_we.
- rst mid-commit: abandons the update. All banks return to unity passthrough; no ack is issued.
- No arithmetic on coefficients; values are passed through bit-exact.

Optional Feature:
EQ_COEFF_READBACK_EN
- Defined: adds ports rd_band (in, BAND_IDX_W), rd_sel (in, 3), rd_src (in, 1: 0=shadow, 1=active) and rd_data (out, COEFF_W).
  - rd_data is registered, 1-cycle latency.
  - Illegal rd_sel or rd_band returns 0.
  - rd_data resets to 0.
- Undefined: ports absent, no readback mux logic.

Decomposition:
- Package eq_coeff_pkg:
  - COEFF_W default
  - wr_sel encoding constants (SEL_A0..SEL_B2)
  - UNITY_Q constant
  - FSM state enum (IDLE, ARMED, UPDATE, DONE)
- Sub-module eq_coeff_bank (one instance per band): six shadow and six active registers, load-shadow and copy-active enables, dirty flag.
- The top level holds the FSM, the priority scan over the dirty mask, and output packing.

Test Plan:
- Reset -> every band: coeff_b field B0 = 65536, A0 = 65536, others 0; coeff_set = 0, wr_ready = 1, busy = 0.
- Write band 2 B1 = 0x3FFFF and A2 = -1234, commit, sample_tick 5 cycles later:
  - coeff_we = 4'b0100 exactly one cycle after the tick, then commit_ack next cycle.
  - Active band 2 shows the new values; other bands unchanged.
- Dirty bands 0 and 3, commit + tick -> coeff_we 0001 then 1000 on consecutive cycles, ack on the third cycle; busy low after ack.
- Commit with no writes -> no coeff_we pulse; commit_ack one cycle after sample_tick.
- Writes with wr_sel = 6 and wr_band = 5 (NUM_BANDS = 4) -> handshake completes, err goes 1 and stays 1; shadow unchanged.
- Assert rst in UPDATE with 3 dirty bands:
  - No further coeff_we and no commit_ack.
  - Outputs back to unity.
  - A subsequent write + commit works normally.
